// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - shared op codes, data/ROB types and helpers for alu_unit
package alu_unit_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_W     = 4;
    localparam int DIV_ITERS = 32;

    typedef logic [XLEN-1:0]  data_t;
    typedef logic [ROB_W-1:0] rob_pos_t;

    localparam rob_pos_t ZERO_ROB = '0;
    localparam logic     TRUE     = 1'b1;
    localparam logic     FALSE    = 1'b0;

    typedef enum logic [5:0] {
        OPENUM_NOP    = 6'd0,
        OPENUM_LUI,
        OPENUM_AUIPC,
        OPENUM_JAL,
        OPENUM_JALR,
        OPENUM_BEQ,
        OPENUM_BNE,
        OPENUM_BLT,
        OPENUM_BGE,
        OPENUM_BLTU,
        OPENUM_BGEU,
        OPENUM_ADD,
        OPENUM_SUB,
        OPENUM_SLL,
        OPENUM_SLT,
        OPENUM_SLTU,
        OPENUM_XOR,
        OPENUM_SRL,
        OPENUM_SRA,
        OPENUM_OR,
        OPENUM_AND,
        OPENUM_ADDI,
        OPENUM_SLTI,
        OPENUM_SLTIU,
        OPENUM_XORI,
        OPENUM_ORI,
        OPENUM_ANDI,
        OPENUM_SLLI,
        OPENUM_SRLI,
        OPENUM_SRAI,
        OPENUM_MUL,
        OPENUM_MULH,
        OPENUM_MULHSU,
        OPENUM_MULHU,
        OPENUM_DIV,
        OPENUM_DIVU,
        OPENUM_REM,
        OPENUM_REMU
    } openum_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

    function automatic logic is_div_class(openum_t op);
        return (op == OPENUM_DIV) || (op == OPENUM_DIVU) ||
               (op == OPENUM_REM) || (op == OPENUM_REMU);
    endfunction

    function automatic logic is_signed_div(openum_t op);
        return (op == OPENUM_DIV) || (op == OPENUM_REM);
    endfunction

    function automatic logic is_rem(openum_t op);
        return (op == OPENUM_REM) || (op == OPENUM_REMU);
    endfunction

endpackage

// File: rtl/alu_unit_serial_divider.sv
// rtl/alu_unit_serial_divider.sv - restoring divider on magnitudes, one quotient bit per cycle
module alu_unit_serial_divider
    import alu_unit_pkg::*;
#(
    parameter int ITERS = DIV_ITERS
)
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  start,
    input  logic  is_signed,
    input  data_t dividend,
    input  data_t divisor,
    input  logic  abort,
    output logic  busy,
    output logic  done,
    output data_t quot,
    output data_t rem
);

    localparam int CW = $clog2(ITERS);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(ITERS - 1);

    div_state_t state, state_next;
    cnt_t       cnt;
    data_t      rem_q, quo_q, dvs_q;
    logic       qneg_q, rneg_q;

    logic [32:0] trial;
    data_t       step_rem, step_quo;
    data_t       a_mag, b_mag;

    // The last iteration is taken combinationally so the result is ready at the final edge.
    assign trial    = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    assign step_rem = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
    assign step_quo = {quo_q[30:0], ~trial[32]};

    assign busy = (state == DIV_RUN);
    assign done = busy && (cnt == LAST);
    assign quot = qneg_q ? -step_quo : step_quo;
    assign rem  = rneg_q ? -step_rem : step_rem;

    assign a_mag = (is_signed && dividend[31]) ? -dividend : dividend;
    assign b_mag = (is_signed && divisor[31])  ? -divisor  : divisor;

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_RUN;
            DIV_RUN:  if (done)  state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
        if (abort) state_next = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= FALSE;
            rneg_q <= FALSE;
        end else if (en) begin
            if (state == DIV_IDLE && start) begin
                cnt    <= '0;
                rem_q  <= '0;
                quo_q  <= a_mag;
                dvs_q  <= b_mag;
                qneg_q <= is_signed && (dividend[31] ^ divisor[31]);
                rneg_q <= is_signed && dividend[31];
            end else if (busy) begin
                cnt   <= cnt + cnt_t'(1);
                rem_q <= step_rem;
                quo_q <= step_quo;
            end
        end
    end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - ALU execution stage with registered CDB broadcast; RV32M_EN adds MUL and a serial divider
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  openum_t  in_rs_op,
    input  data_t    in_rs_value1,
    input  data_t    in_rs_value2,
    input  data_t    in_rs_imm,
    input  rob_pos_t in_rs_rob_pos,
    input  data_t    in_rs_pc,
    input  logic     in_rob_xbp,
    output logic     out_rs_stall,
    output rob_pos_t out_cdb_pos,
    output data_t    out_cdb_value,
    output logic     out_cdb_jump,
    output data_t    out_cdb_target
);

    logic     res_ok;
    data_t    res_value;
    logic     res_jump;
    data_t    res_target;
    logic     accept;
    logic     div_busy;
    logic     div_done;
    data_t    div_value;
    rob_pos_t div_tag;
    logic [4:0] sh_r, sh_i;

    assign sh_r = in_rs_value2[4:0];
    assign sh_i = in_rs_imm[4:0];

`ifdef RV32M_EN
    logic [63:0] mul_a, mul_b, prod;
    logic        div_req, div_start, div_rem_sel;
    data_t       div_quot, div_rem;

    // One 64x64 multiplier; operand extension selects the signedness of each factor.
    assign mul_a = (in_rs_op == OPENUM_MULHU) ? {32'b0, in_rs_value1}
                                              : {{32{in_rs_value1[31]}}, in_rs_value1};
    assign mul_b = (in_rs_op == OPENUM_MULH)  ? {{32{in_rs_value2[31]}}, in_rs_value2}
                                              : {32'b0, in_rs_value2};
    assign prod  = mul_a * mul_b;
`endif

    always_comb begin
        res_ok     = FALSE;
        res_value  = '0;
        res_jump   = FALSE;
        res_target = '0;
`ifdef RV32M_EN
        div_req    = FALSE;
`endif
        case (in_rs_op)
            OPENUM_LUI:   begin res_ok = TRUE; res_value = in_rs_imm; end
            OPENUM_AUIPC: begin res_ok = TRUE; res_value = in_rs_pc + in_rs_imm; end
            OPENUM_JAL: begin
                res_ok     = TRUE;
                res_value  = in_rs_pc + 32'd4;
                res_jump   = TRUE;
                res_target = in_rs_pc + in_rs_imm;
            end
            OPENUM_JALR: begin
                res_ok     = TRUE;
                res_value  = in_rs_pc + 32'd4;
                res_jump   = TRUE;
                res_target = (in_rs_value1 + in_rs_imm) & ~32'd1;
            end
            OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU: begin
                res_ok     = TRUE;
                res_target = in_rs_pc + in_rs_imm;
                case (in_rs_op)
                    OPENUM_BEQ:  res_jump = (in_rs_value1 == in_rs_value2);
                    OPENUM_BNE:  res_jump = (in_rs_value1 != in_rs_value2);
                    OPENUM_BLT:  res_jump = ($signed(in_rs_value1) <  $signed(in_rs_value2));
                    OPENUM_BGE:  res_jump = ($signed(in_rs_value1) >= $signed(in_rs_value2));
                    OPENUM_BLTU: res_jump = (in_rs_value1 <  in_rs_value2);
                    default:     res_jump = (in_rs_value1 >= in_rs_value2);
                endcase
            end
            OPENUM_ADD:   begin res_ok = TRUE; res_value = in_rs_value1 + in_rs_value2; end
            OPENUM_SUB:   begin res_ok = TRUE; res_value = in_rs_value1 - in_rs_value2; end
            OPENUM_SLL:   begin res_ok = TRUE; res_value = in_rs_value1 << sh_r; end
            OPENUM_SLT:   begin res_ok = TRUE; res_value = {31'b0, $signed(in_rs_value1) < $signed(in_rs_value2)}; end
            OPENUM_SLTU:  begin res_ok = TRUE; res_value = {31'b0, in_rs_value1 < in_rs_value2}; end
            OPENUM_XOR:   begin res_ok = TRUE; res_value = in_rs_value1 ^ in_rs_value2; end
            OPENUM_SRL:   begin res_ok = TRUE; res_value = in_rs_value1 >> sh_r; end
            OPENUM_SRA:   begin res_ok = TRUE; res_value = $signed(in_rs_value1) >>> sh_r; end
            OPENUM_OR:    begin res_ok = TRUE; res_value = in_rs_value1 | in_rs_value2; end
            OPENUM_AND:   begin res_ok = TRUE; res_value = in_rs_value1 & in_rs_value2; end
            OPENUM_ADDI:  begin res_ok = TRUE; res_value = in_rs_value1 + in_rs_imm; end
            OPENUM_SLTI:  begin res_ok = TRUE; res_value = {31'b0, $signed(in_rs_value1) < $signed(in_rs_imm)}; end
            OPENUM_SLTIU: begin res_ok = TRUE; res_value = {31'b0, in_rs_value1 < in_rs_imm}; end
            OPENUM_XORI:  begin res_ok = TRUE; res_value = in_rs_value1 ^ in_rs_imm; end
            OPENUM_ORI:   begin res_ok = TRUE; res_value = in_rs_value1 | in_rs_imm; end
            OPENUM_ANDI:  begin res_ok = TRUE; res_value = in_rs_value1 & in_rs_imm; end
            OPENUM_SLLI:  begin res_ok = TRUE; res_value = in_rs_value1 << sh_i; end
            OPENUM_SRLI:  begin res_ok = TRUE; res_value = in_rs_value1 >> sh_i; end
            OPENUM_SRAI:  begin res_ok = TRUE; res_value = $signed(in_rs_value1) >>> sh_i; end
`ifdef RV32M_EN
            OPENUM_MUL:   begin res_ok = TRUE; res_value = prod[31:0]; end
            OPENUM_MULH, OPENUM_MULHSU, OPENUM_MULHU: begin
                res_ok    = TRUE;
                res_value = prod[63:32];
            end
            OPENUM_DIV, OPENUM_DIVU, OPENUM_REM, OPENUM_REMU: begin
                // Zero divisor and signed overflow resolve immediately without the divider.
                if (in_rs_value2 == '0) begin
                    res_ok    = TRUE;
                    res_value = is_rem(in_rs_op) ? in_rs_value1 : 32'hFFFF_FFFF;
                end else if (is_signed_div(in_rs_op) && in_rs_value1 == 32'h8000_0000 &&
                             in_rs_value2 == 32'hFFFF_FFFF) begin
                    res_ok    = TRUE;
                    res_value = is_rem(in_rs_op) ? 32'd0 : 32'h8000_0000;
                end else begin
                    div_req = TRUE;
                end
            end
`endif
            default: ;
        endcase
    end

`ifdef RV32M_EN
    assign div_start    = div_req && accept && !in_rob_xbp;
    assign out_rs_stall = div_busy || is_div_class(in_rs_op);
    assign div_value    = div_rem_sel ? div_rem : div_quot;

    alu_unit_serial_divider #(
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .start     (div_start),
        .is_signed (is_signed_div(in_rs_op)),
        .dividend  (in_rs_value1),
        .divisor   (in_rs_value2),
        .abort     (in_rob_xbp),
        .busy      (div_busy),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_tag     <= ZERO_ROB;
            div_rem_sel <= FALSE;
        end else if (rdy && div_start) begin
            div_tag     <= in_rs_rob_pos;
            div_rem_sel <= is_rem(in_rs_op);
        end
    end
`else
    assign div_busy     = FALSE;
    assign div_done     = FALSE;
    assign div_value    = '0;
    assign div_tag      = ZERO_ROB;
    assign out_rs_stall = FALSE;
`endif

    // Ops arriving while the divider runs violate the stall protocol and are dropped.
    assign accept = !div_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cdb_pos    <= ZERO_ROB;
            out_cdb_value  <= '0;
            out_cdb_jump   <= FALSE;
            out_cdb_target <= '0;
        end else if (rdy) begin
            out_cdb_pos  <= ZERO_ROB;
            out_cdb_jump <= FALSE;
            if (!in_rob_xbp) begin
                if (div_done) begin
                    out_cdb_pos    <= div_tag;
                    out_cdb_value  <= div_value;
                    out_cdb_target <= '0;
                end else if (accept && res_ok) begin
                    out_cdb_pos    <= in_rs_rob_pos;
                    out_cdb_value  <= res_value;
                    out_cdb_jump   <= res_jump;
                    out_cdb_target <= res_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit (vector table, random model, divider sequences)
module tb_alu_unit;
    import alu_unit_pkg::*;

    logic     clk = 1'b0;
    logic     rst, rdy, xbp;
    openum_t  op;
    data_t    v1, v2, imm, pc;
    rob_pos_t tag;
    logic     stall, jump;
    rob_pos_t pos;
    data_t    value, target;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    alu_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_rs_op       (op),
        .in_rs_value1   (v1),
        .in_rs_value2   (v2),
        .in_rs_imm      (imm),
        .in_rs_rob_pos  (tag),
        .in_rs_pc       (pc),
        .in_rob_xbp     (xbp),
        .out_rs_stall   (stall),
        .out_cdb_pos    (pos),
        .out_cdb_value  (value),
        .out_cdb_jump   (jump),
        .out_cdb_target (target)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic  ok;
        data_t value;
        logic  jump;
        data_t target;
        logic  ctl;
    } res_t;

    typedef struct {
        openum_t  op;
        data_t    v1, v2, imm, pc;
        rob_pos_t tag;
        logic     bcast;
        data_t    value;
        logic     jump;
        logic     chk_tgt;
        data_t    target;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input openum_t o, input data_t a, input data_t b, input data_t i,
                         input data_t p, input rob_pos_t t);
        op = o; v1 = a; v2 = b; imm = i; pc = p; tag = t;
        #1;
        if (o != OPENUM_NOP && !is_div_class(o))
            check("proto_no_stall", 32'(stall), 32'd0);
    endtask

    function automatic data_t div_ref(openum_t o, data_t a, data_t b);
        int sa = a;
        int sb = b;
        if (b == 0) return (o == OPENUM_REM || o == OPENUM_REMU) ? a : 32'hFFFF_FFFF;
        if ((o == OPENUM_DIV || o == OPENUM_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (o == OPENUM_DIV) ? 32'h8000_0000 : 32'd0;
        case (o)
            OPENUM_DIV:  return data_t'(sa / sb);
            OPENUM_DIVU: return a / b;
            OPENUM_REM:  return data_t'(sa % sb);
            default:     return a % b;
        endcase
    endfunction

    function automatic res_t model(openum_t o, data_t a, data_t b, data_t i, data_t p);
        res_t r;
        int sa = a;
        int sb = b;
        int si = i;
        longint sp;
        longint unsigned up, ua, ub;
        r = '{ok: 1'b1, value: 32'd0, jump: 1'b0, target: 32'd0, ctl: 1'b0};
        ua = longint'(a);
        ub = longint'(b);
        case (o)
            OPENUM_LUI:   r.value = i;
            OPENUM_AUIPC: r.value = p + i;
            OPENUM_JAL:   begin r.value = p + 4; r.jump = 1; r.ctl = 1; r.target = p + i; end
            OPENUM_JALR:  begin r.value = p + 4; r.jump = 1; r.ctl = 1; r.target = (a + i) & 32'hFFFF_FFFE; end
            OPENUM_BEQ:   begin r.ctl = 1; r.target = p + i; r.jump = (a == b); end
            OPENUM_BNE:   begin r.ctl = 1; r.target = p + i; r.jump = (a != b); end
            OPENUM_BLT:   begin r.ctl = 1; r.target = p + i; r.jump = (sa < sb); end
            OPENUM_BGE:   begin r.ctl = 1; r.target = p + i; r.jump = (sa >= sb); end
            OPENUM_BLTU:  begin r.ctl = 1; r.target = p + i; r.jump = (a < b); end
            OPENUM_BGEU:  begin r.ctl = 1; r.target = p + i; r.jump = (a >= b); end
            OPENUM_ADD:   r.value = a + b;
            OPENUM_SUB:   r.value = a - b;
            OPENUM_SLL:   r.value = a << (b % 32);
            OPENUM_SLT:   r.value = (sa < sb) ? 1 : 0;
            OPENUM_SLTU:  r.value = (a < b) ? 1 : 0;
            OPENUM_XOR:   r.value = a ^ b;
            OPENUM_SRL:   r.value = a >> (b % 32);
            OPENUM_SRA:   r.value = data_t'(sa >>> (b % 32));
            OPENUM_OR:    r.value = a | b;
            OPENUM_AND:   r.value = a & b;
            OPENUM_ADDI:  r.value = a + i;
            OPENUM_SLTI:  r.value = (sa < si) ? 1 : 0;
            OPENUM_SLTIU: r.value = (a < i) ? 1 : 0;
            OPENUM_XORI:  r.value = a ^ i;
            OPENUM_ORI:   r.value = a | i;
            OPENUM_ANDI:  r.value = a & i;
            OPENUM_SLLI:  r.value = a << (i % 32);
            OPENUM_SRLI:  r.value = a >> (i % 32);
            OPENUM_SRAI:  r.value = data_t'(sa >>> (i % 32));
`ifdef RV32M_EN
            OPENUM_MUL:   r.value = a * b;
            OPENUM_MULH:  begin sp = longint'(sa) * longint'(sb); r.value = data_t'(sp >>> 32); end
            OPENUM_MULHSU: begin sp = longint'(sa) * longint'(ub); r.value = data_t'(sp >>> 32); end
            OPENUM_MULHU: begin up = ua * ub; r.value = data_t'(up >> 32); end
            OPENUM_DIV, OPENUM_DIVU, OPENUM_REM, OPENUM_REMU: r.value = div_ref(o, a, b);
`endif
            default:      r.ok = 1'b0;
        endcase
        return r;
    endfunction

`ifdef RV32M_EN
    task automatic do_div(input string name, input openum_t o, input data_t a, input data_t b,
                          input rob_pos_t t);
        int n;
        int lat;
        data_t exp;
        exp = div_ref(o, a, b);
        lat = (b == 0 || ((o == OPENUM_DIV || o == OPENUM_REM) &&
                          a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : DIV_ITERS;
        drive(o, a, b, 32'd0, 32'd0, t);
        check({name, "_stall_issue"}, 32'(stall), 32'd1);
        step();
        drive(OPENUM_NOP, 0, 0, 0, 0, 0);
        n = 0;
        while (stall && n < 100) begin
            check({name, "_no_early_bcast"}, 32'(pos), 32'(ZERO_ROB));
            n++;
            step();
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(lat));
        check({name, "_pos"}, 32'(pos), 32'(t));
        check({name, "_value"}, value, exp);
        step();
        check({name, "_pos_clear"}, 32'(pos), 32'(ZERO_ROB));
    endtask
`endif

    vec_t    vecs[13];
    openum_t rand_ops[$];

    initial begin
        res_t r;
        int   seen;

        rst = 1'b0; rdy = 1'b1; xbp = 1'b0;
        op = OPENUM_NOP; v1 = '0; v2 = '0; imm = '0; pc = '0; tag = '0;
        #12;
        check("rst_pos", 32'(pos), 32'(ZERO_ROB));
        check("rst_value", value, 32'd0);
        check("rst_jump", 32'(jump), 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        vecs[0]  = '{OPENUM_ADD,  32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 4'd5, 1'b1, 32'd4, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{OPENUM_BLT,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd2, 1'b1, 32'd0, 1'b1, 1'b1, 32'h120};
        vecs[2]  = '{OPENUM_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd3, 1'b1, 32'd0, 1'b0, 1'b1, 32'h120};
        vecs[3]  = '{OPENUM_JALR, 32'h1003, 32'd0, 32'd0, 32'h40, 4'd4, 1'b1, 32'h44, 1'b1, 1'b1, 32'h1002};
        vecs[4]  = '{OPENUM_SRA,  32'h8000_0010, 32'h24, 32'd0, 32'd0, 4'd6, 1'b1, 32'hF800_0001, 1'b0, 1'b0, 32'd0};
        vecs[5]  = '{OPENUM_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd7, 1'b1, 32'd1, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{OPENUM_LUI,  32'd0, 32'd0, 32'h1234_5000, 32'd0, 4'd8, 1'b1, 32'h1234_5000, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{OPENUM_AUIPC, 32'd0, 32'd0, 32'hFFFF_F000, 32'h1000, 4'd9, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0};
        vecs[8]  = '{OPENUM_JAL,  32'd0, 32'd0, 32'hFFFF_FF00, 32'h200, 4'd10, 1'b1, 32'h204, 1'b1, 1'b1, 32'h100};
        vecs[9]  = '{openum_t'(6'h3F), 32'd1, 32'd2, 32'd3, 32'd4, 4'd11, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0};
        vecs[10] = '{OPENUM_SUB,  32'd0, 32'd1, 32'd0, 32'd0, 4'd12, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0};
        vecs[11] = '{OPENUM_MUL,  32'h1_0003, 32'h1_0000, 32'd0, 32'd0, 4'd13, M_EN, 32'h0003_0000, 1'b0, 1'b0, 32'd0};
        vecs[12] = '{OPENUM_NOP,  32'd5, 32'd6, 32'd0, 32'd0, 4'd14, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0};

        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].op, vecs[k].v1, vecs[k].v2, vecs[k].imm, vecs[k].pc, vecs[k].tag);
            step();
            check("vec_pos", 32'(pos), vecs[k].bcast ? 32'(vecs[k].tag) : 32'(ZERO_ROB));
            if (vecs[k].bcast) begin
                check("vec_value", value, vecs[k].value);
                check("vec_jump", 32'(jump), 32'(vecs[k].jump));
                if (vecs[k].chk_tgt) check("vec_target", target, vecs[k].target);
            end
        end
        drive(OPENUM_NOP, 0, 0, 0, 0, 0);
        step();
        check("bcast_one_cycle", 32'(pos), 32'(ZERO_ROB));

        drive(OPENUM_ADD, 32'd1, 32'd2, 0, 0, 4'd6);
        step();
        check("freeze_pre_pos", 32'(pos), 32'd6);
        rdy = 1'b0;
        drive(OPENUM_SUB, 32'd9, 32'd1, 0, 0, 4'd7);
        step();
        check("freeze_hold_pos", 32'(pos), 32'd6);
        check("freeze_hold_value", value, 32'd3);
        step();
        check("freeze_hold_pos2", 32'(pos), 32'd6);
        rdy = 1'b1;
        drive(OPENUM_NOP, 0, 0, 0, 0, 0);
        step();
        check("freeze_release_pos", 32'(pos), 32'(ZERO_ROB));

        drive(OPENUM_ADD, 32'd1, 32'd1, 0, 0, 4'd3);
        xbp = 1'b1;
        step();
        xbp = 1'b0;
        check("flush_pos", 32'(pos), 32'(ZERO_ROB));
        check("flush_jump", 32'(jump), 32'd0);
        drive(OPENUM_JAL, 0, 0, 32'h10, 32'h300, 4'd4);
        step();
        check("jal_jump", 32'(jump), 32'd1);

        drive(OPENUM_ADD, 32'd2, 32'd2, 0, 0, 4'd5);
        step();
        check("pulse_pre_pos", 32'(pos), 32'd5);
        #2 rst = 1'b0;
        #1;
        check("pulse_pos", 32'(pos), 32'(ZERO_ROB));
        check("pulse_value", value, 32'd0);
        #1 rst = 1'b1;
        drive(OPENUM_NOP, 0, 0, 0, 0, 0);
        step();

        rand_ops = '{OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR, OPENUM_BEQ, OPENUM_BNE,
                     OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU, OPENUM_ADD, OPENUM_SUB,
                     OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU, OPENUM_XOR, OPENUM_SRL, OPENUM_SRA,
                     OPENUM_OR, OPENUM_AND, OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI,
                     OPENUM_ORI, OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
                     OPENUM_MUL, OPENUM_MULH, OPENUM_MULHSU, OPENUM_MULHU};
        for (int k = 0; k < 300; k++) begin
            openum_t  o;
            data_t    a, b, i, p;
            rob_pos_t t;
            o = rand_ops[$urandom_range(0, rand_ops.size() - 1)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : data_t'($urandom);
            i = $urandom;
            p = $urandom;
            t = rob_pos_t'($urandom_range(1, 15));
            r = model(o, a, b, i, p);
            drive(o, a, b, i, p, t);
            step();
            check("rnd_pos", 32'(pos), r.ok ? 32'(t) : 32'(ZERO_ROB));
            if (r.ok) begin
                check("rnd_value", value, r.value);
                check("rnd_jump", 32'(jump), 32'(r.jump));
                if (r.ctl) check("rnd_target", target, r.target);
            end
        end
        drive(OPENUM_NOP, 0, 0, 0, 0, 0);
        step();

`ifdef RV32M_EN
        do_div("div_m7_2", OPENUM_DIV, 32'hFFFF_FFF9, 32'd2, 4'd9);
        do_div("rem_m7_2", OPENUM_REM, 32'hFFFF_FFF9, 32'd2, 4'd10);
        do_div("divu_by0", OPENUM_DIVU, 32'h1234_5678, 32'd0, 4'd11);
        do_div("remu_by0", OPENUM_REMU, 32'h1234_5678, 32'd0, 4'd12);
        do_div("div_ovf", OPENUM_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13);
        do_div("rem_ovf", OPENUM_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd14);
        for (int k = 0; k < 8; k++) begin
            openum_t o;
            data_t   b;
            o = rand_ops[0];
            case ($urandom_range(0, 3))
                0: o = OPENUM_DIV;
                1: o = OPENUM_DIVU;
                2: o = OPENUM_REM;
                default: o = OPENUM_REMU;
            endcase
            b = ($urandom_range(0, 3) == 0) ? data_t'($urandom_range(1, 9)) : data_t'($urandom);
            do_div("div_rnd", o, data_t'($urandom), b, rob_pos_t'($urandom_range(1, 15)));
        end

        drive(OPENUM_DIV, 32'd100, 32'd7, 0, 0, 4'd12);
        step();
        drive(OPENUM_NOP, 0, 0, 0, 0, 0);
        repeat (5) step();
        xbp = 1'b1;
        step();
        xbp = 1'b0;
        check("flush_run_stall", 32'(stall), 32'd0);
        check("flush_run_pos", 32'(pos), 32'(ZERO_ROB));
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (pos == 4'd12) seen++;
        end
        check("flush_run_no_bcast", 32'(seen), 32'd0);

        drive(OPENUM_DIV, 32'd1000, 32'd3, 0, 0, 4'd13);
        step();
        drive(OPENUM_NOP, 0, 0, 0, 0, 0);
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        check("rst_run_stall", 32'(stall), 32'd0);
        check("rst_run_pos", 32'(pos), 32'(ZERO_ROB));
        #1 rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (pos == 4'd13) seen++;
        end
        check("rst_run_no_bcast", 32'(seen), 32'd0);
        check("rst_run_idle", 32'(stall), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
